// File: rtl/dram_lsu_pkg.sv
// dram_lsu_pkg: shared definitions for the data_ram load/store unit.
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'd3 reserved)
//   - FSM state encoding
//   - default base address of the data_ram window
//   - lane_mask(): byte-enable pattern of a request within its word
package dram_lsu_pkg;

  localparam logic [31:0] DRAM_BASE_DEFAULT = 32'h4000_0000;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RSP    = 3'd5
  } state_t;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << off;
      SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dram_lsu_align.sv
// dram_lsu_align: combinational data steering for dram_lsu.
//   word      in  32  word read from data_ram
//   wdata     in  32  store data, LSB-justified
//   size      in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   off       in  2   byte offset within the word (addr[1:0])
//   sign_ext  in  1   sign-extend sub-word load results
//   load_data out 32  word shifted down to the addressed lane and extended
//   merged    out 32  word with the store lane(s) replaced by wdata
module dram_lsu_align
  import dram_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted_s;
  logic [31:0] wshift_s;
  logic [3:0]  mask_s;

  // Load extract/extend and store lane merge.
  always_comb begin
    shifted_s = word >> {off, 3'b000};
    wshift_s  = wdata << {off, 3'b000};
    mask_s    = lane_mask(size, off);
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: load_data = {{16{sign_ext & shifted_s[15]}}, shifted_s[15:0]};
      default: load_data = shifted_s;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (mask_s[i]) begin
        merged[8*i +: 8] = wshift_s[8*i +: 8];
      end else begin
        merged[8*i +: 8] = word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dram_lsu.sv
// dram_lsu: load/store initiator for data_ram.
// Accepts byte/half/word requests from the core, performs word accesses on
// data_ram (read-modify-write for sub-word stores), honours i_ram_halt with a
// halt timeout, and returns one response pulse per request.
// Optional feature: define LSU_RMW_EN to build the read-modify-write path; when
// undefined, sub-word stores complete immediately with an error.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_req_valid/o_req_ready        request handshake (ready only in IDLE)
//   i_req_we/addr/wdata/size/signed request fields
//   o_rsp_valid/rdata/err          one-cycle response
//   o_daddr/o_ddata/o_dwe/o_dre/o_das  data_ram request side
//   i_ddata, i_ram_halt            data_ram read data and halt
module dram_lsu
  import dram_lsu_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE    = DRAM_BASE_DEFAULT,
  parameter int          DRAM_AW      = 12,
  parameter int          HALT_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_daddr,
  output logic [31:0] o_ddata,
  output logic        o_dwe,
  output logic        o_dre,
  output logic        o_das,
  input  logic [31:0] i_ddata,
  input  logic        i_ram_halt
);

  state_t      state_r, next_state_s;
  logic        we_r, signed_r;
  logic [31:0] addr_r, wdata_r;
  logic [1:0]  size_r;
  logic [31:0] halt_cnt_r;

  logic [31:0] cur_addr_s, cur_wdata_s, offset_s;
  logic [1:0]  cur_size_s;
  logic        cur_signed_s;
  logic        misalign_s, oow_s, req_err_s, access_s, timeout_hit_s;
  logic [31:0] load_data_s, merged_s;

  logic        req_ready_s, rsp_valid_s, rsp_err_s, dwe_s, dre_s, das_s;
  logic [31:0] rsp_rdata_s, daddr_s, ddata_s;

  // Request fields: the live inputs while IDLE (accept cycle), the latched copy otherwise.
  always_comb begin
    if (state_r == IDLE) begin
      cur_addr_s   = i_req_addr;
      cur_wdata_s  = i_req_wdata;
      cur_size_s   = i_req_size;
      cur_signed_s = i_req_signed;
    end else begin
      cur_addr_s   = addr_r;
      cur_wdata_s  = wdata_r;
      cur_size_s   = size_r;
      cur_signed_s = signed_r;
    end
  end

  // Accept-time legality checks and halt-timeout detection.
  always_comb begin
    offset_s   = i_req_addr - DRAM_BASE;
    misalign_s = ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                 ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
    // Unsigned wrap makes addresses below the base land out of window too.
    oow_s      = (offset_s >> (DRAM_AW + 2)) != 32'd0;
    req_err_s  = (i_req_size == 2'd3) || misalign_s || oow_s;
`ifndef LSU_RMW_EN
    if (i_req_we && (i_req_size != SZ_WORD)) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = req_err_s;
    end
`endif
    access_s = (state_r == RD) || (state_r == WR) || (state_r == RMW_RD) || (state_r == RMW_WR);
    if (HALT_TIMEOUT != 0) begin
      timeout_hit_s = access_s && i_ram_halt && (halt_cnt_r == 32'(HALT_TIMEOUT - 1));
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  dram_lsu_align u_align (
    .word      (i_ddata),
    .wdata     (cur_wdata_s),
    .size      (cur_size_s),
    .off       (cur_addr_s[1:0]),
    .sign_ext  (cur_signed_s),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!i_req_valid) begin
          next_state_s = IDLE;
        end else if (req_err_s) begin
          next_state_s = RSP;
        end else if (!i_req_we) begin
          next_state_s = RD;
        end else if (i_req_size == SZ_WORD) begin
          next_state_s = WR;
        end else begin
`ifdef LSU_RMW_EN
          next_state_s = RMW_RD;
`else
          next_state_s = RSP;
`endif
        end
      end
      RD, WR: begin
        if (!i_ram_halt || timeout_hit_s) begin
          next_state_s = RSP;
        end else begin
          next_state_s = state_r;
        end
      end
`ifdef LSU_RMW_EN
      RMW_RD: begin
        if (timeout_hit_s) begin
          next_state_s = RSP;
        end else if (!i_ram_halt) begin
          next_state_s = RMW_WR;
        end else begin
          next_state_s = RMW_RD;
        end
      end
      RMW_WR: begin
        if (!i_ram_halt || timeout_hit_s) begin
          next_state_s = RSP;
        end else begin
          next_state_s = RMW_WR;
        end
      end
`endif
      RSP:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output values for the cycle that starts in next_state_s.
  always_comb begin
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_rdata_s = 32'd0;
    daddr_s     = 32'd0;
    ddata_s     = 32'd0;
    dwe_s       = 1'b0;
    dre_s       = 1'b0;
    das_s       = 1'b0;
    case (next_state_s)
      IDLE: req_ready_s = 1'b1;
      RD: begin
        das_s   = 1'b1;
        dre_s   = 1'b1;
        daddr_s = {cur_addr_s[31:2], 2'b00};
      end
      WR: begin
        das_s   = 1'b1;
        dwe_s   = 1'b1;
        daddr_s = {cur_addr_s[31:2], 2'b00};
        // Word size: every lane comes from wdata, so the merge is just wdata.
        ddata_s = merged_s;
      end
`ifdef LSU_RMW_EN
      RMW_RD: begin
        das_s   = 1'b1;
        dre_s   = 1'b1;
        daddr_s = {cur_addr_s[31:2], 2'b00};
      end
      RMW_WR: begin
        das_s   = 1'b1;
        dwe_s   = 1'b1;
        daddr_s = {cur_addr_s[31:2], 2'b00};
        // Merge once from the word read in RMW_RD, then hold through halts.
        if (state_r == RMW_RD) begin
          ddata_s = merged_s;
        end else begin
          ddata_s = o_ddata;
        end
      end
`endif
      RSP: begin
        rsp_valid_s = 1'b1;
        rsp_err_s   = (state_r == IDLE) || timeout_hit_s;
        if ((state_r == RD) && !we_r && !timeout_hit_s) begin
          rsp_rdata_s = load_data_s;
        end else begin
          rsp_rdata_s = 32'd0;
        end
      end
      default: req_ready_s = 1'b0;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_daddr     <= 32'd0;
      o_ddata     <= 32'd0;
      o_dwe       <= 1'b0;
      o_dre       <= 1'b0;
      o_das       <= 1'b0;
    end else begin
      o_req_ready <= req_ready_s;
      o_rsp_valid <= rsp_valid_s;
      o_rsp_err   <= rsp_err_s;
      o_rsp_rdata <= rsp_rdata_s;
      o_daddr     <= daddr_s;
      o_ddata     <= ddata_s;
      o_dwe       <= dwe_s;
      o_dre       <= dre_s;
      o_das       <= das_s;
    end
  end

  // Request capture at accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_r     <= 1'b0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      size_r   <= 2'd0;
      signed_r <= 1'b0;
    end else if ((state_r == IDLE) && i_req_valid) begin
      we_r     <= i_req_we;
      addr_r   <= i_req_addr;
      wdata_r  <= i_req_wdata;
      size_r   <= i_req_size;
      signed_r <= i_req_signed;
    end else begin
      we_r     <= we_r;
      addr_r   <= addr_r;
      wdata_r  <= wdata_r;
      size_r   <= size_r;
      signed_r <= signed_r;
    end
  end

  // Consecutive halt cycles within the current access state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      halt_cnt_r <= 32'd0;
    end else if (access_s && i_ram_halt && !timeout_hit_s) begin
      halt_cnt_r <= halt_cnt_r + 32'd1;
    end else begin
      halt_cnt_r <= 32'd0;
    end
  end

endmodule

// File: tb/tb_dram_lsu.sv
// tb_dram_lsu: randomized self-checking bench for dram_lsu with a behavioural
// data_ram (halt injection) and a byte-level reference model.
module tb_dram_lsu;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int AW  = 10;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        i_rst, i_req_valid, i_req_we, i_req_signed, i_ram_halt;
  logic [31:0] i_req_addr, i_req_wdata, i_ddata;
  logic [1:0]  i_req_size;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_dwe, o_dre, o_das;
  logic [31:0] o_rsp_rdata, o_daddr, o_ddata;

  logic [31:0] mem    [0:(1<<AW)-1];
  logic [31:0] golden [0:(1<<AW)-1];
  int  n_checks = 0;
  int  n_errors = 0;
  int  halt_left = 0;
  bit  halt_force = 1'b0;

  always #5 clk = ~clk;

  dram_lsu #(.DRAM_BASE(BASE), .DRAM_AW(AW), .HALT_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_size(i_req_size), .i_req_signed(i_req_signed),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_daddr(o_daddr), .o_ddata(o_ddata), .o_dwe(o_dwe), .o_dre(o_dre), .o_das(o_das),
    .i_ddata(i_ddata), .i_ram_halt(i_ram_halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return int'(o[AW-1:0]);
  endfunction

  // data_ram model: write at mid-cycle, halt/read data set just after each edge.
  initial begin
    i_ram_halt = 1'b0;
    i_ddata    = 32'h0;
    forever begin
      @(negedge clk);
      if (o_das && o_dwe && !i_ram_halt) mem[widx(o_daddr)] = o_ddata;
      @(posedge clk);
      #1;
      i_ram_halt = o_das && (halt_force || halt_left > 0);
      if (i_ram_halt && !halt_force) halt_left--;
      i_ddata = (o_das && o_dre) ? mem[widx(o_daddr)] : 32'h0;
    end
  end

  // Reference model: expected error, load data, latency and strobe cycles.
  task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input bit sgn, input int h, input bit stuck,
                       output bit err, output logic [31:0] rdata, output int lat, output int das_cyc);
    int nb, w, b;
    logic [31:0] off, val;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = addr - BASE;
    err = (size == 2'd3) || ((addr % nb) != 0) || (off >= 32'(4 * (1 << AW)));
`ifndef LSU_RMW_EN
    if (we && nb < 4) err = 1'b1;
`endif
    rdata = 32'h0;
    if (err) begin
      lat = 1; das_cyc = 0;
      return;
    end
    if (stuck) begin
      err = 1'b1; lat = 1 + TMO; das_cyc = TMO;
      return;
    end
    lat = 2 + h + ((we && nb < 4) ? 1 : 0);
    das_cyc = lat - 1;
    w = int'(off >> 2);
    b = int'(off % 4);
    if (we) begin
      for (int i = 0; i < nb; i++) golden[w][8*(b+i) +: 8] = wdata[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = golden[w][8*(b+i) +: 8];
      if (sgn && val[8*nb-1]) for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
      rdata = val;
    end
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit sgn, input int h, input bit stuck);
    bit e, got, addr_bad, stab_bad, both_bad, phalt;
    logic [31:0] r, pa, pdd;
    logic pdas, pdre, pdwe;
    int lat, dcyc, das_n, k;
    model(we, addr, wdata, size, sgn, h, stuck, e, r, lat, dcyc);
    k = 0;
    while (!o_req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata;
    i_req_size = size; i_req_signed = sgn;
    halt_left = h; halt_force = stuck;
    @(posedge clk);
    got = 1'b0; addr_bad = 1'b0; stab_bad = 1'b0; both_bad = 1'b0; phalt = 1'b0;
    das_n = 0; pa = 32'h0; pdd = 32'h0; pdas = 1'b0; pdre = 1'b0; pdwe = 1'b0;
    for (k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_req_valid = 1'b0;
        check("busy", {31'd0, o_req_ready}, 32'd0);
      end
      if (o_das) begin
        das_n++;
        if (o_daddr !== {addr[31:2], 2'b00}) addr_bad = 1'b1;
      end
      if (o_dre && o_dwe) both_bad = 1'b1;
      if (phalt && !o_rsp_valid &&
          (o_daddr !== pa || o_das !== pdas || o_dre !== pdre || o_dwe !== pdwe || o_ddata !== pdd))
        stab_bad = 1'b1;
      pa = o_daddr; pdd = o_ddata; pdas = o_das; pdre = o_dre; pdwe = o_dwe; phalt = i_ram_halt;
      if (o_rsp_valid) begin
        got = 1'b1;
        check("latency", k, lat);
        check("rsp_err", {31'd0, o_rsp_err}, {31'd0, e});
        check("rsp_rdata", o_rsp_rdata, r);
        check("rsp_strobes", {29'd0, o_das, o_dre, o_dwe}, 32'd0);
      end
    end
    check("rsp_seen", {31'd0, got}, 32'd1);
    check("das_cycles", das_n, dcyc);
    check("daddr", {31'd0, addr_bad}, 32'd0);
    check("halt_stable", {31'd0, stab_bad}, 32'd0);
    check("dre_dwe_excl", {31'd0, both_bad}, 32'd0);
    halt_force = 1'b0;
    @(negedge clk);
    check("rsp_pulse", {31'd0, o_rsp_valid}, 32'd0);
    check("ready_after", {31'd0, o_req_ready}, 32'd1);
  endtask

  initial begin
    bit bad;
    int nb, lo, sel;
    logic [31:0] a;
    logic [1:0] sz;
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = 32'h0;
    i_req_wdata = 32'h0; i_req_size = 2'd0; i_req_signed = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'(i + 1);
      golden[i] = 32'(i + 1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_ctrl", {27'd0, o_rsp_valid, o_rsp_err, o_dwe, o_dre, o_das}, 32'd0);
    check("rst_data", o_rsp_rdata | o_daddr | o_ddata, 32'd0);
    i_rst = 1'b0;
    @(negedge clk);

    do_req(1'b0, 32'h4000_0004, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    do_req(1'b1, 32'h4000_0008, 32'h1234_5678, 2'd2, 1'b0, 3, 1'b0);
    do_req(1'b0, 32'h4000_0008, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    mem[3] = 32'h80FF_0000; golden[3] = 32'h80FF_0000;
    do_req(1'b0, 32'h4000_000F, 32'h0, 2'd0, 1'b1, 0, 1'b0);
    do_req(1'b0, 32'h4000_000F, 32'h0, 2'd0, 1'b0, 1, 1'b0);
    mem[1] = 32'h1122_3344; golden[1] = 32'h1122_3344;
    do_req(1'b1, 32'h4000_0006, 32'h0000_BEEF, 2'd1, 1'b0, 0, 1'b0);
    do_req(1'b0, 32'h4000_0004, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    do_req(1'b0, 32'h4000_0002, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    do_req(1'b0, 32'h4000_1000, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    do_req(1'b0, 32'h4000_0000, 32'h0, 2'd3, 1'b0, 0, 1'b0);
    do_req(1'b0, 32'h4000_0010, 32'h0, 2'd2, 1'b0, 0, 1'b1);
    do_req(1'b1, 32'h4000_0014, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, 1'b1);

    // Reset in the middle of a halted read: no response, outputs cleared.
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h4000_0020; i_req_size = 2'd2;
    halt_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("midrd_das", {31'd0, o_das}, 32'd1);
    i_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    halt_force = 1'b0;
    i_rst = 1'b0;
    check("abort_ctrl", {27'd0, o_rsp_valid, o_rsp_err, o_dwe, o_dre, o_das}, 32'd0);
    check("abort_data", o_rsp_rdata | o_daddr | o_ddata, 32'd0);
    check("abort_ready", {31'd0, o_req_ready}, 32'd1);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_rsp_valid || o_das) bad = 1'b1;
    end
    check("abort_quiet", {31'd0, bad}, 32'd0);

    for (int t = 0; t < 250; t++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      lo = $urandom_range(0, 3);
      if ($urandom_range(0, 9) != 0) lo = lo & ~(nb - 1);
      sel = $urandom_range(0, 19);
      if (sel == 0) a = $urandom;
      else if (sel == 1) a = BASE + 32'(4 << AW) + 32'($urandom_range(0, 255));
      else a = BASE + 32'($urandom_range(0, 63) * 4 + lo);
      do_req(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b0);
    end

    lo = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem[i] !== golden[i]) lo++;
    check("mem_image", lo, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
